// File: rtl/pwm_bank.sv
// Bank of independent PWM channels with double-buffered high/low times.
// Each channel swaps shadow times into its active set only at a period boundary.
module pwm_bank #(
    parameter int CH = 4,
    parameter int W  = 16,
    parameter int SW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  data_in,
    input  logic [SW-1:0] ch_sel,
    input  logic          low_write,
    input  logic          high_write,
    input  logic [CH-1:0] enable,
    output logic [CH-1:0] pwm_out,
    output logic [CH-1:0] period_done
);

    localparam logic [W-1:0] ZERO = {W{1'b0}};
    localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    state_t        r_state     [CH];
    state_t        w_state_nxt [CH];
    logic [W-1:0]  r_cnt       [CH];
    logic [W-1:0]  w_cnt_nxt   [CH];
    logic [W-1:0]  r_act_h     [CH];
    logic [W-1:0]  w_act_h_nxt [CH];
    logic [W-1:0]  r_act_l     [CH];
    logic [W-1:0]  w_act_l_nxt [CH];
    logic [W-1:0]  r_sh_h      [CH];
    logic [W-1:0]  w_sh_h_nxt  [CH];
    logic [W-1:0]  r_sh_l      [CH];
    logic [W-1:0]  w_sh_l_nxt  [CH];
    logic [CH-1:0] r_pwm;
    logic [CH-1:0] w_pwm_nxt;
    logic [CH-1:0] r_done;
    logic [CH-1:0] w_done_nxt;
    logic [CH-1:0] w_hit;
    logic [CH-1:0] w_load;

    // Next-state, shadow write-through and reload decisions for every channel.
    always_comb begin
        for (int c = 0; c < CH; c++) begin
            // An out-of-range ch_sel never equals any channel index, so it is dropped here.
            w_hit[c]       = (ch_sel == SW'(c));
            w_sh_h_nxt[c]  = (w_hit[c] && high_write) ? data_in : r_sh_h[c];
            w_sh_l_nxt[c]  = (w_hit[c] && low_write)  ? data_in : r_sh_l[c];
            w_state_nxt[c] = r_state[c];
            w_cnt_nxt[c]   = r_cnt[c];
            w_act_h_nxt[c] = r_act_h[c];
            w_act_l_nxt[c] = r_act_l[c];
            w_load[c]      = 1'b0;
            w_done_nxt[c]  = 1'b0;

            if (!enable[c]) begin
                w_state_nxt[c] = ST_IDLE;
                w_cnt_nxt[c]   = ZERO;
            end else begin
                case (r_state[c])
                    ST_IDLE: begin
                        w_load[c] = 1'b1;
                    end
                    ST_HIGH: begin
                        if (r_cnt[c] == ZERO) begin
                            if (r_act_l[c] != ZERO) begin
                                w_state_nxt[c] = ST_LOW;
                                w_cnt_nxt[c]   = r_act_l[c] - ONE;
                            end else begin
                                w_load[c]     = 1'b1;
                                w_done_nxt[c] = 1'b1;
                            end
                        end else begin
                            w_cnt_nxt[c] = r_cnt[c] - ONE;
                        end
                    end
                    ST_LOW: begin
                        if (r_cnt[c] == ZERO) begin
                            w_load[c]     = 1'b1;
                            w_done_nxt[c] = 1'b1;
                        end else begin
                            w_cnt_nxt[c] = r_cnt[c] - ONE;
                        end
                    end
                    default: begin
                        w_state_nxt[c] = ST_IDLE;
                        w_cnt_nxt[c]   = ZERO;
                    end
                endcase

                // Reload uses the post-write shadows so a same-edge write takes effect now.
                if (w_load[c]) begin
                    w_act_h_nxt[c] = w_sh_h_nxt[c];
                    w_act_l_nxt[c] = w_sh_l_nxt[c];
                    if (w_sh_h_nxt[c] != ZERO) begin
                        w_state_nxt[c] = ST_HIGH;
                        w_cnt_nxt[c]   = w_sh_h_nxt[c] - ONE;
                    end else if (w_sh_l_nxt[c] != ZERO) begin
                        w_state_nxt[c] = ST_LOW;
                        w_cnt_nxt[c]   = w_sh_l_nxt[c] - ONE;
                    end else begin
                        w_state_nxt[c] = ST_IDLE;
                        w_cnt_nxt[c]   = ZERO;
                    end
                end else begin
                    w_act_h_nxt[c] = r_act_h[c];
                    w_act_l_nxt[c] = r_act_l[c];
                end
            end

            w_pwm_nxt[c] = (w_state_nxt[c] == ST_HIGH);
        end
    end

    // Channel state, time registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < CH; c++) begin
                r_state[c] <= ST_IDLE;
                r_cnt[c]   <= ZERO;
                r_act_h[c] <= ZERO;
                r_act_l[c] <= ZERO;
                r_sh_h[c]  <= ZERO;
                r_sh_l[c]  <= ZERO;
            end
            r_pwm  <= {CH{1'b0}};
            r_done <= {CH{1'b0}};
        end else begin
            for (int c = 0; c < CH; c++) begin
                r_state[c] <= w_state_nxt[c];
                r_cnt[c]   <= w_cnt_nxt[c];
                r_act_h[c] <= w_act_h_nxt[c];
                r_act_l[c] <= w_act_l_nxt[c];
                r_sh_h[c]  <= w_sh_h_nxt[c];
                r_sh_l[c]  <= w_sh_l_nxt[c];
            end
            r_pwm  <= w_pwm_nxt;
            r_done <= w_done_nxt;
        end
    end

    assign pwm_out     = r_pwm;
    assign period_done = r_done;

endmodule

// File: tb/tb_pwm_bank.sv
// Directed bench for pwm_bank: expectations are queued per cycle and checked
// against the registered outputs one time unit after each rising edge.
module tb_pwm_bank;

    localparam int CH = 4;
    localparam int W  = 16;
    localparam int SW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  data_in;
    logic [SW-1:0] ch_sel;
    logic          low_write;
    logic          high_write;
    logic [CH-1:0] enable;
    logic [CH-1:0] pwm_out;
    logic [CH-1:0] period_done;

    int errors = 0;
    int checks = 0;

    string tag_q  [$];
    int    ch_q   [$];
    logic  pwm_q  [$];
    logic  done_q [$];

    always #5 clk = ~clk;

    pwm_bank #(.CH(CH), .W(W), .SW(SW)) dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .ch_sel      (ch_sel),
        .low_write   (low_write),
        .high_write  (high_write),
        .enable      (enable),
        .pwm_out     (pwm_out),
        .period_done (period_done)
    );

    task automatic expect_ch(input string tag, input int ch, input logic pwm, input logic done);
        tag_q.push_back(tag);
        ch_q.push_back(ch);
        pwm_q.push_back(pwm);
        done_q.push_back(done);
    endtask

    task automatic expect_all_zero(input string tag);
        for (int c = 0; c < CH; c++) expect_ch(tag, c, 1'b0, 1'b0);
    endtask

    task automatic check_now();
        string t;
        int    c;
        logic  ep;
        logic  ed;
        while (tag_q.size() > 0) begin
            t  = tag_q.pop_front();
            c  = ch_q.pop_front();
            ep = pwm_q.pop_front();
            ed = done_q.pop_front();
            checks++;
            assert (pwm_out[c] === ep) else begin
                errors++;
                $error("FAIL %s ch%0d pwm_out observed=%b expected=%b", t, c, pwm_out[c], ep);
            end
            checks++;
            assert (period_done[c] === ed) else begin
                errors++;
                $error("FAIL %s ch%0d period_done observed=%b expected=%b", t, c, period_done[c], ed);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check_now();
    endtask

    task automatic drive_write(input int ch, input logic hw, input logic lw, input int val);
        ch_sel     = SW'(ch);
        data_in    = W'(val);
        high_write = hw;
        low_write  = lw;
    endtask

    task automatic clear_write();
        high_write = 1'b0;
        low_write  = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        enable = {CH{1'b0}};
        data_in = {W{1'b0}};
        ch_sel = {SW{1'b0}};
        clear_write();

        // Reset state
        #1;
        expect_all_zero("reset_async");
        check_now();
        expect_all_zero("reset_held");
        tick();
        rst = 1'b0;

        // ch0 3/2
        drive_write(0, 1'b1, 1'b0, 3);
        expect_ch("ch0_wr_idle", 0, 1'b0, 1'b0);
        tick();
        drive_write(0, 1'b0, 1'b1, 2);
        expect_ch("ch0_wr_idle", 0, 1'b0, 1'b0);
        tick();
        clear_write();
        enable = 4'b0001;
        for (int k = 0; k < 15; k++) begin
            expect_ch("ch0_3_2", 0, (k % 5) < 3, (k >= 5) && (k % 5 == 0));
            tick();
        end
        enable = 4'b0000;
        expect_ch("ch0_disable_at_end", 0, 1'b0, 1'b0);
        tick();

        // ch1 4/4 with high=1 written mid-HIGH
        drive_write(1, 1'b1, 1'b0, 4);
        tick();
        drive_write(1, 1'b0, 1'b1, 4);
        tick();
        clear_write();
        enable = 4'b0010;
        for (int k = 0; k < 21; k++) begin
            if (k == 2) drive_write(1, 1'b1, 1'b0, 1);
            else clear_write();
            if (k < 8) expect_ch("ch1_4_4", 1, k < 4, 1'b0);
            else expect_ch("ch1_1_4", 1, ((k - 8) % 5) == 0, ((k - 8) % 5) == 0);
            tick();
        end
        clear_write();

        // ch1 dropped mid-LOW, new high written while idle, then re-enabled
        enable = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) drive_write(1, 1'b1, 1'b0, 2);
            else clear_write();
            expect_ch("ch1_disabled", 1, 1'b0, 1'b0);
            tick();
        end
        clear_write();
        enable = 4'b0010;
        for (int m = 0; m < 7; m++) begin
            expect_ch("ch1_restart_2_4", 1, (m % 6) < 2, (m > 0) && (m % 6 == 0));
            tick();
        end
        enable = 4'b0000;
        expect_ch("ch1_off", 1, 1'b0, 1'b0);
        tick();

        // ch2 5/0 constant high, then 0/0 via both strobes, then write-through on idle load
        drive_write(2, 1'b1, 1'b0, 5);
        tick();
        drive_write(2, 1'b0, 1'b1, 0);
        tick();
        clear_write();
        enable = 4'b0100;
        for (int k = 0; k < 16; k++) begin
            if (k == 7) drive_write(2, 1'b1, 1'b1, 0);
            else if (k == 13) drive_write(2, 1'b1, 1'b0, 2);
            else clear_write();
            expect_ch("ch2_const", 2, (k < 10) || (k >= 13), (k == 5) || (k == 10) || (k == 15));
            tick();
        end
        clear_write();
        enable = 4'b0000;
        expect_ch("ch2_off", 2, 1'b0, 1'b0);
        tick();

        // ch3 7/7 via both strobes; out-of-range ch_sel write must touch nothing
        drive_write(3, 1'b1, 1'b1, 7);
        tick();
        drive_write(5, 1'b1, 1'b1, 1);
        tick();
        clear_write();
        enable = 4'b1010;
        for (int k = 0; k < 15; k++) begin
            expect_ch("ch3_7_7", 3, (k % 14) < 7, (k > 0) && (k % 14 == 0));
            expect_ch("ch1_kept_2_4", 1, (k % 6) < 2, (k > 0) && (k % 6 == 0));
            expect_ch("ch0_idle", 0, 1'b0, 1'b0);
            expect_ch("ch2_idle", 2, 1'b0, 1'b0);
            tick();
        end
        enable = 4'b0000;
        expect_all_zero("all_off");
        tick();

        // ch0 rst pulse during HIGH
        enable = 4'b0001;
        for (int k = 0; k < 2; k++) begin
            expect_ch("ch0_pre_rst", 0, 1'b1, 1'b0);
            tick();
        end
        rst = 1'b1;
        #2;
        expect_ch("ch0_rst_async", 0, 1'b0, 1'b0);
        check_now();
        drive_write(0, 1'b1, 1'b1, 3);
        expect_all_zero("rst_held");
        tick();
        expect_all_zero("rst_held");
        tick();
        clear_write();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            expect_ch("ch0_post_rst", 0, 1'b0, 1'b0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pwm_bank.md
PWM_BANK -- requirements
Module: pwm_bank

Interface
REQ-001 Parameter CH, default 4, number of independent PWM channels (1..16).
REQ-002 Parameter W, default 16, width of time values and phase counters (4..32).
REQ-003 Parameter SW, default 2, width of ch_sel; SHALL satisfy 2**SW >= CH.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 data_in  input  W  time value, in clk cycles, for a write.
REQ-007 ch_sel  input  SW  channel addressed by the current write.
REQ-008 low_write  input  1  single-cycle strobe: data_in -> shadow low time of ch_sel.
REQ-009 high_write  input  1  single-cycle strobe: data_in -> shadow high time of ch_sel.
REQ-010 enable  input  CH  per-channel run enable, level-sensitive.
REQ-011 pwm_out  output  CH  registered PWM outputs.
REQ-012 period_done  output  CH  registered one-cycle pulse at each channel's period boundary.

Function
REQ-013 Each channel SHALL hold shadow_h/shadow_l (written by host) and act_h/act_l (used by the counter).
REQ-014 A write SHALL update the shadow of channel ch_sel on the strobe edge; a ch_sel >= CH SHALL be ignored.
REQ-015 low_write and high_write asserted together SHALL load data_in into both shadows of ch_sel.
REQ-016 Shadow writes SHALL NOT affect the running period; act_h/act_l SHALL load from shadows only at a load point.
REQ-017 Load points: the first edge with enable=1 in IDLE, and the period-end edge (last cycle of LOW, or last cycle of HIGH when act_l=0).
REQ-018 A write on the same edge as a load point SHALL be captured by the shadow and used by that load (write-through).
REQ-019 Per-channel states: IDLE, HIGH, LOW; W-bit down-counter cnt.
REQ-020 IDLE: pwm_out=0; at a load point with new act_h>0 -> HIGH, cnt=act_h-1, pwm_out=1 next cycle.
REQ-021 IDLE/load with act_h=0, act_l>0 -> LOW, cnt=act_l-1, pwm_out=0.
REQ-022 Load with act_h=0 and act_l=0 -> IDLE, pwm_out=0, re-evaluating at every subsequent edge while enabled.
REQ-023 HIGH: pwm_out=1 for exactly act_h cycles; at cnt=0 -> LOW with cnt=act_l-1 if act_l>0, else period end.
REQ-024 LOW: pwm_out=0 for exactly act_l cycles; at cnt=0 -> period end.
REQ-025 Period end SHALL reload actives and restart per REQ-020..022 with no idle gap; period = act_h+act_l cycles.
REQ-026 act_l=0, act_h>0 SHALL give pwm_out constantly 1; act_h=0, act_l>0 constantly 0.
REQ-027 period_done SHALL be 1 in the cycle after each period-end edge, 0 otherwise.
REQ-028 enable deassert SHALL force IDLE, pwm_out=0, period_done=0 on the next edge regardless of state; shadows retained.
REQ-029 Time values SHALL be unsigned W-bit; maximum 2**W-1 SHALL be supported without wrap.
REQ-030 Channels SHALL be fully independent; no cross-channel phase alignment.

Reset
REQ-031 rst=1 SHALL asynchronously clear pwm_out, period_done, cnt, act_h, act_l, shadows to 0, state IDLE.
REQ-032 Writes and enable SHALL be ignored while rst=1; operation resumes on the first edge after release.
REQ-033 rst mid-period SHALL drive pwm_out=0 immediately, without waiting for clk.

Verification (CH=4, W=16)
REQ-034 ch0 high=3, low=2, enable[0]=1 -> pwm_out[0] 1,1,1,0,0 repeating; period_done[0] every 5 cycles.
REQ-035 ch1 running 4/4, write high=1 mid-HIGH -> current period stays 4/4, next period 1/4.
REQ-036 ch2 high=5, low=0 -> pwm_out[2] constant 1, period_done[2] every 5 cycles; then high=0, low=0 -> 0 after boundary.
REQ-037 Both strobes, ch_sel=3, data_in=7 -> ch3 7/7; ch_sel=5 write -> no channel changes.
REQ-038 ch0 3/2 running, rst pulse in HIGH -> pwm_out=0 at once; after release with enable=1 stays 0 (shadows cleared).
REQ-039 enable[1] dropped mid-LOW -> IDLE next edge; re-enabled -> period restarts from HIGH with shadow values.
